// File: rtl/matmul_mac_engine.sv
// -----------------------------------------------------------------------------
// matmul_mac_engine
// Computes C = A*B for N x N matrices by sequential multiply-accumulate. Each
// C element takes N MAC cycles, then waits in WRITE until the consumer takes
// it through the valid/ready result port. A and B live in internal register
// files. They are loaded one element at a time while the engine is idle.
//
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous active-low reset
//   ld_en       - write ld_data into A (ld_sel=0) or B (ld_sel=1) at ld_addr
//   ld_sel      - register file select for the load port
//   ld_addr     - row-major element index (row*N + col)
//   ld_data     - element value
//   start       - begin a multiplication (accepted only when idle)
//   signed_mode - 1 = two's-complement elements, 0 = unsigned (latched at start)
//   busy        - high from the accepting start edge until DONE is left
//   done        - one-cycle pulse after the final result is accepted
//   r_valid     - result element available
//   r_ready     - consumer accepts the result
//   r_addr      - C index i*N + j of the presented result
//   r_data      - C[i][j], extended to ACCW bits according to the mode
// -----------------------------------------------------------------------------
module matmul_mac_engine #(
   parameter int N  = 3,
   parameter int DW = 16,
   localparam int IW   = $clog2(N*N),
   localparam int ACCW = 2*DW + $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ld_en,
   input  logic            ld_sel,
   input  logic [IW-1:0]   ld_addr,
   input  logic [DW-1:0]   ld_data,
   input  logic            start,
   input  logic            signed_mode,
   output logic            busy,
   output logic            done,
   output logic            r_valid,
   input  logic            r_ready,
   output logic [IW-1:0]   r_addr,
   output logic [ACCW-1:0] r_data
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N-1);
   // One bit wider than the address, so that N*N is representable even when it is a power of two.
   localparam logic [IW:0] LOAD_LIMIT = (IW+1)'(N*N);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

   state_t r_state;
   state_t w_nextState;

   logic [DW-1:0]   r_memA [N*N];
   logic [DW-1:0]   r_memB [N*N];
   logic [CW-1:0]   r_i;
   logic [CW-1:0]   r_j;
   logic [CW-1:0]   r_k;
   logic [ACCW-1:0] r_acc;
   logic            r_signed;

   logic [IW-1:0]   w_aIdx;
   logic [IW-1:0]   w_bIdx;
   logic [IW-1:0]   w_cIdx;
   logic [DW-1:0]   w_aElem;
   logic [DW-1:0]   w_bElem;
   logic [2*DW-1:0] w_aExt;
   logic [2*DW-1:0] w_bExt;
   logic [2*DW-1:0] w_prod;
   logic [ACCW-1:0] w_prodExt;
   logic [ACCW-1:0] w_accNext;
   logic            w_lastK;
   logic            w_lastElem;
   logic            w_loadOk;

   assign w_aIdx     = IW'(r_i * N + r_k);
   assign w_bIdx     = IW'(r_k * N + r_j);
   assign w_cIdx     = IW'(r_i * N + r_j);
   assign w_aElem    = r_memA[w_aIdx];
   assign w_bElem    = r_memB[w_bIdx];
   assign w_lastK    = (r_k == LAST_IDX);
   assign w_lastElem = (r_i == LAST_IDX) && (r_j == LAST_IDX);
   assign w_loadOk   = ld_en && (r_state == S_IDLE) && ({1'b0, ld_addr} < LOAD_LIMIT);

   // Operands are extended to 2*DW before multiplying. The truncated product is then
   // exact in both modes, because a signed DW x DW product always fits in 2*DW bits.
   assign w_aExt    = {{DW{r_signed & w_aElem[DW-1]}}, w_aElem};
   assign w_bExt    = {{DW{r_signed & w_bElem[DW-1]}}, w_bElem};
   assign w_prod    = w_aExt * w_bExt;
   assign w_prodExt = {{(ACCW-2*DW){r_signed & w_prod[2*DW-1]}}, w_prod};
   assign w_accNext = r_acc + w_prodExt;

   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);
   assign r_valid = (r_state == S_WRITE);

   // Matrix storage has no reset, so its contents survive a reset. Writes are
   // blocked while rst is low, and whenever the engine is not idle.
   always_ff @(posedge clk) begin
      if (rst && w_loadOk) begin
         if (ld_sel) begin
            r_memB[ld_addr] <= ld_data;
         end else begin
            r_memA[ld_addr] <= ld_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nextState = S_MAC;
         S_MAC:   if (w_lastK) w_nextState = S_WRITE;
         S_WRITE: if (r_ready) w_nextState = w_lastElem ? S_DONE : S_MAC;
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Index counters, accumulator and the result register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_i      <= '0;
         r_j      <= '0;
         r_k      <= '0;
         r_acc    <= '0;
         r_signed <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_signed <= signed_mode;
                  r_i      <= '0;
                  r_j      <= '0;
                  r_k      <= '0;
                  r_acc    <= '0;
               end
            end
            S_MAC: begin
               r_acc <= w_accNext;
               r_k   <= r_k + 1'b1;
               if (w_lastK) begin
                  r_data <= w_accNext;
                  r_addr <= w_cIdx;
               end
            end
            S_WRITE: begin
               if (r_ready && !w_lastElem) begin
                  r_acc <= '0;
                  r_k   <= '0;
                  if (r_j == LAST_IDX) begin
                     r_j <= '0;
                     r_i <= r_i + 1'b1;
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_mac_engine.sv
module tb_matmul_mac_engine;

   localparam int N         = 3;
   localparam int DW        = 16;
   localparam int IW        = $clog2(N*N);
   localparam int ACCW      = 2*DW + $clog2(N);
   localparam int NN        = N*N;
   localparam int RUN_EDGES = NN*(N+1);

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            ld_en = 1'b0;
   logic            ld_sel = 1'b0;
   logic [IW-1:0]   ld_addr = '0;
   logic [DW-1:0]   ld_data = '0;
   logic            start = 1'b0;
   logic            signed_mode = 1'b0;
   logic            busy;
   logic            done;
   logic            r_valid;
   logic            r_ready = 1'b1;
   logic [IW-1:0]   r_addr;
   logic [ACCW-1:0] r_data;

   logic [DW-1:0] modelA [NN];
   logic [DW-1:0] modelB [NN];

   int vectors = 0;
   int miscompares = 0;

   matmul_mac_engine #(.N(N), .DW(DW)) dut (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
      .ld_data(ld_data), .start(start), .signed_mode(signed_mode), .busy(busy),
      .done(done), .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr), .r_data(r_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: C[i][j] = sum_k A[i][k]*B[k][j] in 64-bit arithmetic, then cut to ACCW bits.
   function automatic logic [ACCW-1:0] refElem(input int i, input int j, input bit sgn);
      longint sum = 0;
      longint a;
      longint b;
      logic [63:0] s;
      for (int k = 0; k < N; k++) begin
         a = sgn ? longint'($signed(modelA[i*N+k])) : longint'(modelA[i*N+k]);
         b = sgn ? longint'($signed(modelB[k*N+j])) : longint'(modelB[k*N+j]);
         sum += a * b;
      end
      s = sum;
      return s[ACCW-1:0];
   endfunction

   task automatic loadElem(input bit sel, input int addr, input logic [DW-1:0] val);
      ld_en = 1'b1; ld_sel = sel; ld_addr = IW'(addr); ld_data = val;
      tick();
      ld_en = 1'b0;
      if (addr < NN) begin
         if (sel) modelB[addr] = val;
         else modelA[addr] = val;
      end
   endtask

   // Runs one multiplication. It optionally stalls r_ready at one address,
   // resets at a chosen edge, injects a load plus a restart while the engine is busy,
   // or loads B[4] on the same edge that accepts start.
   task automatic applyStimulus(input bit sgn, input int stallAddr, input int stallCycles,
                                input int resetEdge, input int injectEdge, input bit simLoad,
                                input bit useConst, input logic [ACCW-1:0] constExp);
      int e = 0;
      int outIdx = 0;
      int stallsLeft = stallCycles;
      int firstValid = -1;
      bit doneSeen = 1'b0;
      bit stalledPrev = 1'b0;
      logic [IW-1:0]   heldAddr = '0;
      logic [ACCW-1:0] heldData = '0;
      logic [ACCW-1:0] expC [NN];

      start = 1'b1; signed_mode = sgn; r_ready = 1'b1;
      if (simLoad) begin
         ld_en = 1'b1; ld_sel = 1'b1; ld_addr = IW'(4); ld_data = 16'h1234;
         modelB[4] = 16'h1234;
      end
      for (int idx = 0; idx < NN; idx++) expC[idx] = refElem(idx / N, idx % N, sgn);
      tick();
      start = 1'b0; ld_en = 1'b0; signed_mode = ~sgn;
      checkOutput("busyAfterStart", busy, 1);

      while (!doneSeen && e < RUN_EDGES + stallCycles + 20) begin
         if (r_valid && firstValid < 0) begin
            firstValid = e;
            checkOutput("firstValidEdge", e, N);
         end
         if (stalledPrev) begin
            checkOutput("stallValid", r_valid, 1);
            checkOutput("stallAddr", r_addr, heldAddr);
            checkOutput("stallData", r_data, heldData);
         end
         stalledPrev = 1'b0;
         if (r_valid && int'(r_addr) == stallAddr && stallsLeft > 0) begin
            r_ready = 1'b0; stallsLeft--; stalledPrev = 1'b1;
            heldAddr = r_addr; heldData = r_data;
         end else begin
            r_ready = 1'b1;
         end
         if (r_valid && r_ready) begin
            checkOutput("resultAddr", r_addr, outIdx);
            checkOutput("resultData", r_data, (outIdx < NN) ? expC[outIdx] : '0);
            if (useConst) checkOutput("resultConst", r_data, constExp);
            outIdx++;
         end
         if (e + 1 == injectEdge) begin
            ld_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 16'h0007; start = 1'b1;
         end
         if (e + 1 == resetEdge) rst = 1'b0;
         tick();
         e++;
         ld_en = 1'b0; start = 1'b0;
         if (e == resetEdge) begin
            checkOutput("rstBusy", busy, 0);
            checkOutput("rstValid", r_valid, 0);
            checkOutput("rstDone", done, 0);
            checkOutput("rstData", r_data, 0);
            checkOutput("rstAddr", r_addr, 0);
            rst = 1'b1;
            r_ready = 1'b1;
            return;
         end
         if (done) begin
            doneSeen = 1'b1;
            checkOutput("doneEdge", e, RUN_EDGES + stallCycles);
            checkOutput("doneCount", outIdx, NN);
            checkOutput("busyAtDone", busy, 1);
         end
      end
      r_ready = 1'b1;
      if (!doneSeen) begin
         checkOutput("doneTimeout", 0, 1);
      end else begin
         tick();
         checkOutput("busyFall", busy, 0);
         checkOutput("donePulse", done, 0);
      end
   endtask

   initial begin
      $display("[TB] matmul_mac_engine N=%0d DW=%0d", N, DW);
      repeat (3) tick();
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetDone", done, 0);
      checkOutput("resetValid", r_valid, 0);
      checkOutput("resetAddr", r_addr, 0);
      checkOutput("resetData", r_data, 0);
      rst = 1'b1;
      tick();

      // Identity A times B = 1..9.
      for (int a = 0; a < NN; a++) loadElem(1'b0, a, (a / N == a % N) ? 16'd1 : 16'd0);
      for (int a = 0; a < NN; a++) loadElem(1'b1, a, DW'(a + 1));
      applyStimulus(1'b0, -1, 0, -1, -1, 1'b0, 1'b0, '0);

      // Five-cycle stall at r_addr 4 pushes done to edge 41.
      applyStimulus(1'b0, 4, 5, -1, -1, 1'b0, 1'b0, '0);

      // Reset at edge 10, then rerun from the retained matrices.
      applyStimulus(1'b0, -1, 0, 10, -1, 1'b0, 1'b0, '0);
      tick();
      applyStimulus(1'b0, -1, 0, -1, -1, 1'b0, 1'b0, '0);

      // A write and a second start while busy are both ignored.
      applyStimulus(1'b0, -1, 0, -1, 7, 1'b0, 1'b0, '0);
      loadElem(1'b0, 0, 16'h0007);
      applyStimulus(1'b0, -1, 0, -1, -1, 1'b0, 1'b0, '0);

      // An out-of-range write is dropped, and a load on the start edge is used by that run.
      loadElem(1'b0, 12, 16'hBEEF);
      applyStimulus(1'b0, -1, 0, -1, -1, 1'b1, 1'b0, '0);

      // Signed: (-1)*2 summed over three terms gives -6.
      for (int a = 0; a < NN; a++) loadElem(1'b0, a, 16'hFFFF);
      for (int a = 0; a < NN; a++) loadElem(1'b1, a, 16'h0002);
      applyStimulus(1'b1, -1, 0, -1, -1, 1'b0, 1'b1, 34'h3FFFFFFFA);

      // Unsigned maximum values must not wrap.
      for (int a = 0; a < NN; a++) loadElem(1'b1, a, 16'hFFFF);
      applyStimulus(1'b0, -1, 0, -1, -1, 1'b0, 1'b1, 34'h2FFFA0003);

      // Random matrices, random mode and random stalls.
      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < NN; a++) loadElem(1'b0, a, DW'($urandom));
         for (int a = 0; a < NN; a++) loadElem(1'b1, a, DW'($urandom));
         applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, NN-1), $urandom_range(0, 4),
                       -1, -1, 1'b0, 1'b0, '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/matmul_mac_engine.md
# matmul_mac_engine

Parametrised N×N matrix-multiply engine that computes C = A·B by sequential multiply-accumulate and streams each result element out through a valid/ready port. It holds A and B in internal register files, which are loaded through a word-write port. It is the generalised successor to the fixed 3×3 row/column fetch datapath. It adds configurable dimension and data width, signed/unsigned mode, result backpressure, and a start/busy/done handshake.

## Interface
Parameters:
- N, 3: matrix dimension (N ≥ 2)
- DW, 16: element width of A and B
- Derived: IW = $clog2(N*N); ACCW = 2*DW + $clog2(N)

Ports:
- clk, in, 1: clock. All logic is rising-edge.
- rst, in, 1: reset. **Synchronous, active-low**: rst = 0 sampled at a rising edge resets the block.
- ld_en, in, 1: write one element into A or B this cycle.
- ld_sel, in, 1: 0 selects A, 1 selects B.
- ld_addr, in, IW: row-major element index (row*N + col).
- ld_data, in, DW: element value.
- start, in, 1: start a multiplication. Accepted only in IDLE.
- signed_mode, in, 1: sampled at start. 1 = two's-complement, 0 = unsigned.
- busy, out, 1: high from the edge that accepts start until the edge that leaves DONE.
- done, out, 1: one-cycle pulse after the last result is accepted.
- r_valid, out, 1: result element present on the result port.
- r_ready, in, 1: consumer accepts the result.
- r_addr, out, IW: C index, i*N + j.
- r_data, out, ACCW: C[i][j]. Sign-extended in signed mode, zero-extended otherwise.

## Operation
- **Reset values:** busy = 0, done = 0, r_valid = 0, r_addr = 0, r_data = 0. State = IDLE, i = j = k = 0, acc = 0. A/B storage is **not** cleared by reset; contents are retained.
- **Loading:** ld_en is honoured only in IDLE. In any other state the write is dropped. A write to an address ≥ N*N is dropped.
- **States:**
  - IDLE: if start = 1, latch signed_mode, clear i, j, k and acc, then go to MAC. Otherwise stay.
  - MAC: each cycle, acc ← acc + A[i*N+k] × B[k*N+j], using the latched mode for extension. k increments. After the k = N−1 update, go to WRITE with r_data ← final acc and r_addr ← i*N+j.
  - WRITE: r_valid = 1, with r_data and r_addr held stable. When r_valid & r_ready:
    - if i = j = N−1, go to DONE;
    - otherwise advance j, wrapping to 0 and incrementing i; clear acc and k; go to MAC.
  - DONE: done = 1 and busy = 1 for exactly one cycle, then go to IDLE.
- **Output order:** results emerge in row-major order, r_addr = 0 … N*N−1.
- **Width:** products are 2*DW bits. The ACCW accumulator cannot overflow for N terms in either mode.
- **Ignored inputs:** start is ignored outside IDLE. signed_mode is ignored outside the accepting edge.
- **Reset mid-operation:** a low rst in any state forces the reset values at that edge. The in-flight result is discarded, with no partial done. A subsequent start recomputes from the retained A and B.
- **Simultaneous start and ld_en in IDLE:** the write is performed and start is accepted in the same edge. The MAC sequence uses the newly written value.

## Timing
- **Per element:** N MAC cycles plus at least one WRITE cycle.
- **With r_ready tied high:**
  - first r_valid appears N cycles after the start edge;
  - done is high in the cycle starting N*N*(N+1) edges after the start edge (36 edges for N = 3);
  - busy is high for N*N*(N+1)+1 cycles.
- **Backpressure:** each cycle with r_valid = 1 and r_ready = 0 delays done by exactly one cycle.
- **Throughput:** one element per N+1 cycles. There is no pipelining across elements.

## Test plan
- **Identity:** N = 3, A = I, B = 1..9, signed_mode = 0, r_ready = 1 → r_data = 1..9 at r_addr 0..8; done pulses at edge 36 after start; busy falls on the next edge.
- **Signed:** A all 0xFFFF (−1), B all 0x0002, signed_mode = 1 → every r_data = 0x3FFFFFFFA (−6 in 34 bits).
- **Unsigned max:** A = B all 0xFFFF, signed_mode = 0 → every r_data = 0x2FFFA0003, with no wrap.
- **Backpressure:** identity case with r_ready = 0 for 5 cycles while r_addr = 4 → r_valid, r_addr and r_data stay stable (4, 5); done moves to edge 41.
- **Reset mid-op:** rst = 0 at edge 10 after start → busy = r_valid = done = 0 at that edge. Start again without reloading → identical 1..9 sequence.
- **Busy protection:** ld_en writing A[0] = 0x7 and a second start both asserted while busy → results unchanged, sequence not restarted. After done, the A[0] write in IDLE takes effect on the next run.
